// File: rtl/saber_hit_scheduler.sv
// Per-frame swing/hit scheduler: one shared intersection_detector evaluates both players in turn.
// Optional score_out counters are built when SABER_HIT_SCORE_EN is defined.

package saber_hit_pkg;
  localparam int unsigned X_W = 11;
  localparam int unsigned Y_W = 10;

  typedef struct packed {
    logic [X_W-1:0] rect_x;
    logic [Y_W-1:0] rect_y;
    logic [X_W-1:0] rect_x_2;
    logic [Y_W-1:0] rect_y_2;
  } location_t;

  localparam int unsigned LOC_W = $bits(location_t);
endpackage

// Closed segment vs. the four sides of a box; a segment wholly inside the box does not intersect.
module intersection_detector
  import saber_hit_pkg::*;
(
  input  logic [X_W-1:0] seg_x0,
  input  logic [Y_W-1:0] seg_y0,
  input  logic [X_W-1:0] seg_x1,
  input  logic [Y_W-1:0] seg_y1,
  input  location_t      box,
  output logic           is_intersecting
);
  localparam int unsigned C_W = 13;
  localparam int unsigned P_W = 28;

  typedef logic signed [C_W-1:0] coord_t;
  typedef logic signed [P_W-1:0] prod_t;

  function automatic prod_t orient(input coord_t ax, input coord_t ay, input coord_t bx,
                                   input coord_t by, input coord_t px, input coord_t py);
    prod_t ux, uy, vx, vy;
    ux = P_W'(bx) - P_W'(ax);
    uy = P_W'(by) - P_W'(ay);
    vx = P_W'(px) - P_W'(ax);
    vy = P_W'(py) - P_W'(ay);
    return ux * vy - uy * vx;
  endfunction

  function automatic logic straddles(input prod_t a, input prod_t b);
    logic a_le, a_ge, b_le, b_ge;
    a_le = a[P_W-1] || (a == '0);
    a_ge = !a[P_W-1];
    b_le = b[P_W-1] || (b == '0);
    b_ge = !b[P_W-1];
    return (a_le && b_ge) || (a_ge && b_le);
  endfunction

  function automatic coord_t cmin(input coord_t a, input coord_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic coord_t cmax(input coord_t a, input coord_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic seg_cross(input coord_t p0x, input coord_t p0y, input coord_t p1x,
                                     input coord_t p1y, input coord_t ax, input coord_t ay,
                                     input coord_t bx, input coord_t by);
    logic bbox_ok;
    bbox_ok = (cmin(p0x, p1x) <= cmax(ax, bx)) && (cmin(ax, bx) <= cmax(p0x, p1x)) &&
              (cmin(p0y, p1y) <= cmax(ay, by)) && (cmin(ay, by) <= cmax(p0y, p1y));
    return bbox_ok &&
           straddles(orient(ax, ay, bx, by, p0x, p0y), orient(ax, ay, bx, by, p1x, p1y)) &&
           straddles(orient(p0x, p0y, p1x, p1y, ax, ay), orient(p0x, p0y, p1x, p1y, bx, by));
  endfunction

  coord_t x0, y0, x1, y1, lft, top, rgt, bot;

  always_comb begin
    x0  = {2'b00, seg_x0};
    y0  = {3'b000, seg_y0};
    x1  = {2'b00, seg_x1};
    y1  = {3'b000, seg_y1};
    lft = {2'b00, box.rect_x};
    top = {3'b000, box.rect_y};
    rgt = {2'b00, box.rect_x_2};
    bot = {3'b000, box.rect_y_2};
    is_intersecting = seg_cross(x0, y0, x1, y1, lft, top, rgt, top) ||
                      seg_cross(x0, y0, x1, y1, lft, bot, rgt, bot) ||
                      seg_cross(x0, y0, x1, y1, lft, top, lft, bot) ||
                      seg_cross(x0, y0, x1, y1, rgt, top, rgt, bot);
  end
endmodule

module saber_hit_scheduler
  import saber_hit_pkg::*;
#(
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned MIN_SWING_LEN   = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               frame_valid_in,
  input  logic [2*X_W-1:0]   saber_x_in,
  input  logic [2*Y_W-1:0]   saber_y_in,
  input  logic [1:0]         swing_in,
  input  logic [2*LOC_W-1:0] body_in,
  output logic [1:0]         hit_out,
  output logic               frame_done_out,
  output logic               busy_out,
  output logic               frame_drop_out
`ifdef SABER_HIT_SCORE_EN
  ,
  output logic [7:0]         score_out
`endif
);
  localparam int unsigned CD_W  = $clog2(COOLDOWN_FRAMES + 1);
  localparam int unsigned LEN_W = 13;
  localparam int unsigned D_W   = 12;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EVAL, S_COMMIT} state_t;

  state_t state_q, state_d;
  logic   p_q;

  logic [1:0][X_W-1:0] fx_q, sx_q;
  logic [1:0][Y_W-1:0] fy_q, sy_q;
  logic [1:0]          fsw_q, armed_q, lock_q;
  location_t [1:0]     fbody_q;
  logic [1:0][CD_W-1:0] cd_q;

  logic [X_W-1:0] det_x0_q, det_x1_q;
  logic [Y_W-1:0] det_y0_q, det_y1_q;
  location_t      det_box_q;
  logic           det_c, det_q;

  logic signed [D_W-1:0] ddx, ddy;
  logic [D_W-1:0]        adx, ady;
  logic [LEN_W-1:0]      swing_len;
  logic                  elig_c, fire_c;
  logic [1:0]            hit_d;
  logic                  done_d, busy_d, drop_d;

  intersection_detector u_det (
    .seg_x0          (det_x0_q),
    .seg_y0          (det_y0_q),
    .seg_x1          (det_x1_q),
    .seg_y1          (det_y1_q),
    .box             (det_box_q),
    .is_intersecting (det_c)
  );

  // Eligibility of the player currently being evaluated; state regs only change at COMMIT exit.
  always_comb begin
    ddx       = $signed({1'b0, fx_q[p_q]}) - $signed({1'b0, sx_q[p_q]});
    ddy       = $signed({2'b00, fy_q[p_q]}) - $signed({2'b00, sy_q[p_q]});
    adx       = ddx[D_W-1] ? D_W'(-ddx) : D_W'(ddx);
    ady       = ddy[D_W-1] ? D_W'(-ddy) : D_W'(ddy);
    swing_len = LEN_W'(adx) + LEN_W'(ady);
    elig_c    = fsw_q[p_q] && armed_q[p_q] && !lock_q[p_q] && (cd_q[p_q] == '0) &&
                (swing_len >= LEN_W'(MIN_SWING_LEN));
    fire_c    = elig_c && det_c;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and next registered outputs; hit/done are set one edge early so they show during COMMIT.
  always_comb begin
    state_d = state_q;
    hit_d   = '0;
    done_d  = 1'b0;
    busy_d  = busy_out;
    drop_d  = frame_valid_in && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (frame_valid_in) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: state_d = S_EVAL;
      S_EVAL: begin
        state_d  = S_COMMIT;
        hit_d[0] = !p_q && fire_c;
        hit_d[1] = p_q && fire_c;
        done_d   = p_q;
      end
      S_COMMIT: begin
        if (p_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      p_q            <= 1'b0;
      fx_q           <= '0;
      fy_q           <= '0;
      fsw_q          <= '0;
      fbody_q        <= '0;
      sx_q           <= '0;
      sy_q           <= '0;
      armed_q        <= '0;
      lock_q         <= '0;
      cd_q           <= '0;
      det_x0_q       <= '0;
      det_y0_q       <= '0;
      det_x1_q       <= '0;
      det_y1_q       <= '0;
      det_box_q      <= '0;
      det_q          <= 1'b0;
      hit_out        <= '0;
      frame_done_out <= 1'b0;
      busy_out       <= 1'b0;
      frame_drop_out <= 1'b0;
    end else begin
      hit_out        <= hit_d;
      frame_done_out <= done_d;
      busy_out       <= busy_d;
      frame_drop_out <= drop_d;
      case (state_q)
        S_IDLE: begin
          if (frame_valid_in) begin
            p_q <= 1'b0;
            for (int p = 0; p < 2; p++) begin
              fx_q[p]    <= saber_x_in[p*X_W +: X_W];
              fy_q[p]    <= saber_y_in[p*Y_W +: Y_W];
              fsw_q[p]   <= swing_in[p];
              fbody_q[p] <= body_in[p*LOC_W +: LOC_W];
            end
          end
        end
        S_LOAD: begin
          det_x0_q  <= sx_q[p_q];
          det_y0_q  <= sy_q[p_q];
          det_x1_q  <= fx_q[p_q];
          det_y1_q  <= fy_q[p_q];
          det_box_q <= fbody_q[~p_q];
        end
        S_EVAL: det_q <= det_c;
        S_COMMIT: begin
          p_q <= ~p_q;
          if (!fsw_q[p_q]) begin
            armed_q[p_q] <= 1'b0;
            lock_q[p_q]  <= 1'b0;
          end else if (!armed_q[p_q]) begin
            sx_q[p_q]    <= fx_q[p_q];
            sy_q[p_q]    <= fy_q[p_q];
            armed_q[p_q] <= 1'b1;
          end else if (elig_c && det_q) begin
            lock_q[p_q] <= 1'b1;
          end
          // Reload on a hit, otherwise count down toward zero once per frame.
          if (elig_c && det_q)        cd_q[p_q] <= CD_W'(COOLDOWN_FRAMES);
          else if (cd_q[p_q] != '0)   cd_q[p_q] <= cd_q[p_q] - CD_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SABER_HIT_SCORE_EN
  // Saturating per-player hit counters, advanced on the same edge as hit_out.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      score_out <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (hit_d[p] && (score_out[p*4 +: 4] != 4'hF))
          score_out[p*4 +: 4] <= score_out[p*4 +: 4] + 4'd1;
      end
    end
  end
`endif
endmodule
